// File: rtl/five_bit_serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop, one bit per clock.
// Define SERIAL_ADDSUB_EN to add a sub input that computes A-B instead.
module five_bit_serial_adder #(
   parameter int WIDTH = 5,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADDSUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [CNT_W-1:0] idx;
   logic             carry;
   logic             carry_next;
   logic             s;
   logic             load;
   logic             last;
   logic             sub_op;

`ifdef SERIAL_ADDSUB_EN
   assign sub_op = sub;
`else
   assign sub_op = 1'b0;
`endif

   assign load = start && (state == S_IDLE || state == S_DONE);
   assign last = (state == S_ADD) && (idx == CNT_W'(WIDTH - 1));

   assign s          = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_next = (a_sh[0] & b_sh[0])
                     | (a_sh[0] & carry)
                     | (b_sh[0] & carry);
   assign res_next   = {s, res_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: if (start) state_next = S_ADD;
         S_ADD:  if (last)  state_next = S_DONE;
         S_DONE: state_next = start ? S_ADD : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_ADD);
      done = (state == S_DONE);
   end

   // Subtraction is A + ~B + 1, so the carry flop seeds the +1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         res_sh    <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else if (load) begin
         a_sh   <= a;
         b_sh   <= sub_op ? ~b : b;
         res_sh <= '0;
         idx    <= '0;
         carry  <= sub_op;
      end else if (state == S_ADD) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         res_sh <= res_next;
         carry  <= carry_next;
         idx    <= idx + 1'b1;
         if (last) begin
            sum       <= res_next;
            carry_out <= carry_next;
         end
      end
   end

endmodule

// File: tb/tb_five_bit_serial_adder.sv
// Randomised bench for five_bit_serial_adder with a cycle-level reference model.
// Directed cases pin the model with hand-computed results.
module tb_five_bit_serial_adder;

   localparam int WIDTH = 5;
`ifdef SERIAL_ADDSUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             sub = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   five_bit_serial_adder #(.WIDTH(WIDTH), .CNT_W(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
`ifdef SERIAL_ADDSUB_EN
      .sub(sub),
`endif
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .sum(sum),
      .carry_out(carry_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: an accepted request yields its result WIDTH edges later.
   int             rem = 0;
   logic           m_done = 1'b0;
   logic [WIDTH-1:0] m_sum = '0;
   logic           m_c = 1'b0;
   logic [WIDTH:0] pend = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem    <= 0;
         m_done <= 1'b0;
         m_sum  <= '0;
         m_c    <= 1'b0;
      end else if (rem != 0) begin
         rem    <= rem - 1;
         m_done <= (rem == 1);
         if (rem == 1) {m_c, m_sum} <= pend;
      end else begin
         m_done <= 1'b0;
         if (start) begin
            pend <= {1'b0, a} + {1'b0, (sub ? ~b : b)} + (WIDTH+1)'(sub);
            rem  <= WIDTH;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (busy !== (rem != 0) || done !== m_done ||
             sum !== m_sum || carry_out !== m_c) begin
            errors++;
            $display("FAIL model t=%0t busy/done/sum/c got %b/%b/%0d/%b want %b/%b/%0d/%b",
                     $time, busy, done, sum, carry_out,
                     (rem != 0), m_done, m_sum, m_c);
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic kick(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic s);
      @(posedge clk);
      #2;
      start = 1'b1;
      a = x;
      b = y;
      sub = s;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s timeout got done=0 want done=1", name);
      end
   endtask

   task automatic op(input string name, input logic [WIDTH-1:0] x,
                     input logic [WIDTH-1:0] y, input logic s,
                     input int ws, input int wc);
      kick(x, y, s);
      wait_done(name);
      chk({name, "_sum"}, int'(sum), ws);
      chk({name, "_c"}, int'(carry_out), wc);
   endtask

   initial begin
      int t0;
      int npulse;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sum", int'(sum), 0);
      #20;
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // 1: basic add and hold
      op("t1", 5'd9, 5'd4, 1'b0, 13, 0);
      repeat (10) @(negedge clk);
      chk("t1_hold", int'(sum), 13);

      // 2: overflow
      op("t2a", 5'd31, 5'd1, 1'b0, 0, 1);
      op("t2b", 5'd31, 5'd31, 1'b0, 30, 1);

      // 3: back-to-back with start held
      @(posedge clk);
      #2;
      start = 1'b1;
      a = 5'd3;
      b = 5'd3;
      wait_done("t3a");
      chk("t3a_sum", int'(sum), 6);
      t0 = cyc;
      a = 5'd10;
      b = 5'd20;
      wait_done("t3b");
      chk("t3b_sum", int'(sum), 30);
      chk("t3_period", cyc - t0, WIDTH + 1);
      start = 1'b0;

      // 4: start and operand changes during ADD are ignored
      kick(5'd12, 5'd5, 1'b0);
      @(posedge clk);
      #2;
      start = 1'b1;
      a = 5'd1;
      b = 5'd1;
      @(posedge clk);
      #2;
      start = 1'b0;
      a = 5'd31;
      b = 5'd31;
      wait_done("t4");
      chk("t4_sum", int'(sum), 17);
      npulse = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) npulse++;
      end
      chk("t4_pulses", npulse, 0);

      // 5: reset mid-operation
      kick(5'd7, 5'd8, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_busy", int'(busy), 0);
      chk("t5_done", int'(done), 0);
      chk("t5_sum", int'(sum), 0);
      chk("t5_c", int'(carry_out), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      op("t5b", 5'd2, 5'd2, 1'b0, 4, 0);

      // 6: subtraction
      if (HAS_SUB) begin
         op("t6a", 5'd20, 5'd7, 1'b1, 13, 1);
         op("t6b", 5'd3, 5'd5, 1'b1, 30, 0);
      end

      // random traffic; the compare process checks each cycle
      for (int i = 0; i < 60; i++) begin
         logic s;
         s = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
         kick(WIDTH'($urandom), WIDTH'($urandom), s);
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         wait_done("rand");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
